// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO bank controller: register map defaults,
// serial-word field positions and the readback word layout.
package gpio_pkg;

   localparam int MAX_BANKS   = 8;
   localparam int MAX_WIDTH   = 16;

   // serial_data = {mask[31:16], value[15:0]}
   localparam int MASK_LSB    = 16;
   localparam int VAL_LSB     = 0;

   localparam int RB_PIN_LSB  = 0;
   localparam int RB_STAT_LSB = 16;

   localparam logic [6:0] BASE_OE_DEF   = 7'd40;
   localparam logic [6:0] BASE_OUT_DEF  = 7'd48;
   localparam logic [6:0] BASE_EDGE_DEF = 7'd56;

   typedef struct packed {
      logic [15:0] status;
      logic [15:0] pins;
   } rb_word_t;

endpackage

// File: rtl/gpio_in_cond.sv
// Per-bank input conditioning: 2-flop synchroniser, optional debounce
// (GPIO_DEBOUNCE_EN), previous-state flop and rising-edge detect.
module gpio_in_cond #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pad,
   output logic [WIDTH-1:0] pin_state,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] sync1, sync2, prev;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= pad;
         sync2 <= sync1;
         prev  <= pin_state;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      logic [CW-1:0] cnt;
      logic          st;

      // Any sample that agrees with the held state restarts the count.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            cnt <= '0;
            st  <= 1'b0;
         end else if (sync2[i] == st) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            st  <= sync2[i];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign pin_state[i] = st;
   end
`else
   assign pin_state = sync2;
`endif

   assign rise = pin_state & ~prev;

endmodule

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank controller: masked serial writes to OE/OUT/edge-enable registers,
// sticky rising-edge status with irq, and a one-cycle readback path.
// Optional debounce on inputs is enabled with GPIO_DEBOUNCE_EN.
module gpio_bank_ctrl
   import gpio_pkg::*;
#(
   parameter int         NUM_BANKS       = 4,
   parameter int         WIDTH           = 16,
   parameter logic [6:0] BASE_OE         = BASE_OE_DEF,
   parameter logic [6:0] BASE_OUT        = BASE_OUT_DEF,
   parameter logic [6:0] BASE_EDGE       = BASE_EDGE_DEF,
   parameter int         DEBOUNCE_CYCLES = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [6:0]                 serial_addr,
   input  logic [31:0]                serial_data,
   input  logic                       serial_strobe,
   input  logic [NUM_BANKS*WIDTH-1:0] io_in,
   output logic [NUM_BANKS*WIDTH-1:0] io_oe,
   output logic [NUM_BANKS*WIDTH-1:0] io_out,
   input  logic                       rb_req,
   input  logic [2:0]                 rb_bank,
   output logic                       rb_valid,
   output logic [31:0]                rb_data,
   output logic                       irq
);

   logic [WIDTH-1:0] wr_mask, wr_val;
   assign wr_mask = serial_data[MASK_LSB +: WIDTH];
   assign wr_val  = serial_data[VAL_LSB  +: WIDTH];

   logic [NUM_BANKS-1:0][WIDTH-1:0] oe_q, out_q, pin_state, rise, status_q, status_d;

   gpio_in_cond #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_in [NUM_BANKS-1:0] (
      .clock     (clock),
      .reset_n   (reset_n),
      .pad       (io_in),
      .pin_state (pin_state),
      .rise      (rise)
   );

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic             wr_oe, wr_out, wr_edge, rb_hit;
      logic [WIDTH-1:0] oe_r, out_r, en_r, stat_r, stat_nxt;

      assign wr_oe   = serial_strobe && (serial_addr == BASE_OE   + 7'(b));
      assign wr_out  = serial_strobe && (serial_addr == BASE_OUT  + 7'(b));
      assign wr_edge = serial_strobe && (serial_addr == BASE_EDGE + 7'(b));
      assign rb_hit  = rb_req && (rb_bank == 3'(b));

      // A new edge wins over a same-cycle readback clear so it is never lost.
      assign stat_nxt = (stat_r & ~{WIDTH{rb_hit}}) | (rise[b] & en_r);

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            oe_r   <= '0;
            out_r  <= '0;
            en_r   <= '0;
            stat_r <= '0;
         end else begin
            if (wr_oe)   oe_r  <= (oe_r  & ~wr_mask) | (wr_val & wr_mask);
            if (wr_out)  out_r <= (out_r & ~wr_mask) | (wr_val & wr_mask);
            if (wr_edge) en_r  <= (en_r  & ~wr_mask) | (wr_val & wr_mask);
            stat_r <= stat_nxt;
         end
      end

      assign oe_q[b]     = oe_r;
      assign out_q[b]    = out_r;
      assign status_q[b] = stat_r;
      assign status_d[b] = stat_nxt;
   end

   assign io_oe  = oe_q;
   assign io_out = out_q;

   // Snapshot uses pre-update status; out-of-range banks read as zero.
   rb_word_t snap;
   always_comb begin
      snap = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (rb_bank == 3'(b)) begin
            snap.status[WIDTH-1:0] = status_q[b];
            snap.pins[WIDTH-1:0]   = pin_state[b];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rb_valid <= 1'b0;
         rb_data  <= '0;
         irq      <= 1'b0;
      end else begin
         rb_valid <= rb_req;
         if (rb_req) rb_data <= snap;
         irq <= |status_d;
      end
   end

endmodule
